sync_filter_bank: RTL and testbench
===================================

# sync_filter_bank

Parametrised multi-channel input register bank for the BeebSCSI CPLD. Each channel passes an asynchronous input (BBC 1MHz bus strobes, SCSI REQ/ACK/RST, host nRST) through a configurable synchroniser chain and a consecutive-sample glitch filter. It produces a clean registered level plus one-cycle rise/fall event pulses. It replaces ad-hoc chains of single D flip-flops at the CPLD input boundary.

## Interface
- WIDTH, 8: number of independent channels (1..16).
- STAGES, 2: synchroniser flip-flops per channel (1..4).
- FILTER, 3: consecutive differing samples required before Q changes (1..16).
- RESET_VAL, {WIDTH{1'b0}}: per-channel reset level for the chain and Q.

- CLK  input  1  system clock; all state updates on the rising edge.
- nCLR  input  1  reset, synchronous and active-low; applied only on a CLK rising edge.
- EN  input  1  clock enable; low freezes all state.
- D  input  WIDTH  asynchronous channel inputs.
- Q  output  WIDTH  filtered, registered channel levels.
- RISE  output  WIDTH  one-cycle pulse per channel when Q goes 0->1.
- FALL  output  WIDTH  one-cycle pulse per channel when Q goes 1->0.
- CHANGED  output  1  registered OR of all RISE|FALL bits, coincident with them.

## Operation
- Per channel i: chain s[0..STAGES-1]. s[0] <= D[i], s[k] <= s[k-1]. Filter input is sync = s[STAGES-1].
- Per channel counter cnt, width max(1, ceil(log2(FILTER))), saturating-free. The rules below keep it at or below FILTER-1.
- Each enabled edge, per channel:
  - sync == Q[i]: cnt <= 0; Q holds; RISE/FALL <= 0.
  - sync != Q[i] and cnt < FILTER-1: cnt <= cnt+1; Q holds; RISE/FALL <= 0.
  - sync != Q[i] and cnt == FILTER-1: Q[i] <= sync; cnt <= 0; RISE[i] <= sync; FALL[i] <= ~sync.
- FILTER=1: Q follows sync with one cycle of delay and no glitch rejection.
- CHANGED <= |(next RISE | next FALL). It is registered, so it is never a combinational OR of the outputs.
- Channels are fully independent. Simultaneous events on several channels all pulse in the same cycle.
- EN low: chain, cnt, Q hold; RISE, FALL and CHANGED are forced to 0 on that edge. No event is lost, because the pending change completes after EN returns.
- nCLR low at an edge takes precedence over EN and all other inputs:
  - every chain stage and Q become RESET_VAL;
  - cnt becomes 0;
  - RISE, FALL and CHANGED become 0.
- Reset mid-count discards the partial count; no pulse is generated for the discarded transition.
- The first enabled edge after reset compares against RESET_VAL. An input already differing from RESET_VAL produces a normal RISE/FALL after the full latency.

## Timing
- Reset values: Q = RESET_VAL, RISE = 0, FALL = 0, CHANGED = 0. All are registered outputs.
- Latency, with D stable before enabled edge 1 and all edges enabled:
  - sync reflects D after edge STAGES;
  - Q, RISE/FALL and CHANGED update on edge STAGES+FILTER.
  - Default parameters give 5 edges.
- Glitch rejection: a sync pulse lasting fewer than FILTER cycles leaves Q unchanged and produces no pulse. A pulse of exactly FILTER cycles is accepted.
- A bounce that returns sync to Q resets cnt to 0. The full FILTER count then restarts on the next difference.
- RISE/FALL are high for exactly one enabled cycle per Q change. Minimum spacing between successive pulses on one channel is FILTER cycles.
- EN-low cycles add exactly one cycle of latency per frozen edge.

## Test plan
- Reset: D=8'hFF, nCLR low for 2 edges, RESET_VAL=0 -> Q=8'h00, RISE=FALL=0, CHANGED=0. With nCLR high, RISE=8'hFF and CHANGED=1 on edge 5 only, and Q=8'hFF from edge 5.
- Latency/pulse: defaults, D[3] 0->1 before edge 1 -> Q[3]=1 and RISE[3]=1 on edge 5, RISE[3]=0 on edge 6. D[3] 1->0 later -> FALL[3] one cycle, 5 edges after.
- Glitch: D[0] high for 3 cycles with STAGES=2, FILTER=3 -> Q[0]=1 after edge 5. D[0] high for 2 cycles -> Q[0] stays 0, no pulse. Bounce 1,1,0,1,1,1 -> Q changes only after the last three 1s.
- Simultaneous/independent: D=8'h81 from 8'h00 -> RISE=8'h81 in one cycle, CHANGED=1 for exactly one cycle. Other channels are unaffected.
- EN freeze: EN low for 3 cycles mid-count -> Q, cnt and chain hold, no pulses. Q changes 3 edges later than nominal, and the pulse still occurs exactly once.
- Reset mid-operation and FILTER=1/STAGES=1 build: nCLR low with cnt=2 -> no pulse, Q=RESET_VAL. With FILTER=1, STAGES=1, Q follows D on edge 2.

Source files
------------

// File: rtl/sync_filter_bank_if.sv
// rtl/sync_filter_bank_if.sv - channel inputs, enable and filtered outputs of sync_filter_bank
interface sync_filter_bank_if #(
    parameter int WIDTH = 8
);
    logic             EN;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;
    logic             CHANGED;

    modport master (
        output EN,
        output D,
        input  Q,
        input  RISE,
        input  FALL,
        input  CHANGED
    );

    modport slave (
        input  EN,
        input  D,
        output Q,
        output RISE,
        output FALL,
        output CHANGED
    );
endinterface

// File: rtl/sync_filter_bank.sv
// rtl/sync_filter_bank.sv - per-channel synchroniser chain plus consecutive-sample glitch filter with edge pulses
module sync_filter_bank #(
    parameter int               WIDTH     = 8,
    parameter int               STAGES    = 2,
    parameter int               FILTER    = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic CLK,
    input  logic nCLR,
    sync_filter_bank_if.slave bus
);

    localparam int               CNT_W   = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] chain [STAGES];
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;
    logic             changed_r;

    assign sync = chain[STAGES-1];

    // A channel only commits a new level after FILTER consecutive samples disagree with Q;
    // any sample agreeing with Q restarts the count from zero.
    always_comb begin
        q_nxt    = q_r;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == q_r[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                cnt_nxt[i]  = '0;
                q_nxt[i]    = sync[i];
                rise_nxt[i] = sync[i];
                fall_nxt[i] = ~sync[i];
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            for (int k = 0; k < STAGES; k++) begin
                chain[k] <= RESET_VAL;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            q_r       <= RESET_VAL;
            rise_r    <= '0;
            fall_r    <= '0;
            changed_r <= 1'b0;
        end else if (bus.EN) begin
            chain[0] <= bus.D;
            for (int k = 1; k < STAGES; k++) begin
                chain[k] <= chain[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            q_r       <= q_nxt;
            rise_r    <= rise_nxt;
            fall_r    <= fall_nxt;
            changed_r <= |(rise_nxt | fall_nxt);
        end else begin
            // Frozen edge: state holds so a pending change still completes later, but pulses drop.
            rise_r    <= '0;
            fall_r    <= '0;
            changed_r <= 1'b0;
        end
    end

    assign bus.Q       = q_r;
    assign bus.RISE    = rise_r;
    assign bus.FALL    = fall_r;
    assign bus.CHANGED = changed_r;

endmodule

// File: tb/tb_sync_filter_bank.sv
// tb/tb_sync_filter_bank.sv - directed self-checking bench for sync_filter_bank
module tb_sync_filter_bank;

    logic CLK = 1'b0;
    logic nCLR;

    int errors = 0;
    int checks = 0;

    logic [7:0] sticky_rise;
    logic [7:0] sticky_fall;
    logic [7:0] bounce [8];

    sync_filter_bank_if #(.WIDTH(8)) b0 ();
    sync_filter_bank_if #(.WIDTH(8)) b1 ();

    sync_filter_bank #(
        .WIDTH(8), .STAGES(2), .FILTER(3), .RESET_VAL(8'h00)
    ) u_dut (
        .CLK  (CLK),
        .nCLR (nCLR),
        .bus  (b0.slave)
    );

    sync_filter_bank #(
        .WIDTH(8), .STAGES(1), .FILTER(1), .RESET_VAL(8'h00)
    ) u_fast (
        .CLK  (CLK),
        .nCLR (nCLR),
        .bus  (b1.slave)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_d(input logic [7:0] v);
        b0.D = v;
        b1.D = v;
    endtask

    task automatic set_en(input logic v);
        b0.EN = v;
        b1.EN = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bounce[0] = 8'h01; bounce[1] = 8'h01; bounce[2] = 8'h00; bounce[3] = 8'h01;
        bounce[4] = 8'h01; bounce[5] = 8'h01; bounce[6] = 8'h01; bounce[7] = 8'h01;

        // Reset with inputs high
        nCLR = 1'b0;
        set_en(1'b1);
        set_d(8'hFF);
        run(2);
        check("rst_q",       b0.Q, 8'h00);
        check("rst_rise",    b0.RISE, 8'h00);
        check("rst_fall",    b0.FALL, 8'h00);
        check("rst_changed", b0.CHANGED, 1'b0);
        check("rst_fast_q",  b1.Q, 8'h00);

        // Input already differing from RESET_VAL
        nCLR = 1'b1;
        step();
        check("fast_e1_q", b1.Q, 8'h00);
        step();
        check("fast_e2_q",    b1.Q, 8'hFF);
        check("fast_e2_rise", b1.RISE, 8'hFF);
        run(2);
        check("post_rst_e4_q",       b0.Q, 8'h00);
        check("post_rst_e4_changed", b0.CHANGED, 1'b0);
        check("fast_e4_rise",        b1.RISE, 8'h00);
        step();
        check("post_rst_e5_q",       b0.Q, 8'hFF);
        check("post_rst_e5_rise",    b0.RISE, 8'hFF);
        check("post_rst_e5_changed", b0.CHANGED, 1'b1);
        step();
        check("post_rst_e6_rise",    b0.RISE, 8'h00);
        check("post_rst_e6_changed", b0.CHANGED, 1'b0);
        check("post_rst_e6_q",       b0.Q, 8'hFF);

        // Clean restart with inputs low
        nCLR = 1'b0;
        set_d(8'h00);
        step();
        check("rst2_q", b0.Q, 8'h00);
        nCLR = 1'b1;

        // Latency and pulse width on channel 3
        set_d(8'h08);
        run(4);
        check("lat_e4_q", b0.Q, 8'h00);
        step();
        check("lat_e5_q",    b0.Q, 8'h08);
        check("lat_e5_rise", b0.RISE, 8'h08);
        step();
        check("lat_e6_rise", b0.RISE, 8'h00);
        set_d(8'h00);
        run(4);
        check("fall_e4_fall", b0.FALL, 8'h00);
        step();
        check("fall_e5_fall", b0.FALL, 8'h08);
        check("fall_e5_q",    b0.Q, 8'h00);
        step();
        check("fall_e6_fall", b0.FALL, 8'h00);

        // Three-cycle pulse is accepted
        set_d(8'h01);
        run(3);
        set_d(8'h00);
        run(2);
        check("glitch3_e5_q",    b0.Q, 8'h01);
        check("glitch3_e5_rise", b0.RISE, 8'h01);
        run(3);
        check("glitch3_e8_fall", b0.FALL, 8'h01);
        check("glitch3_e8_q",    b0.Q, 8'h00);

        // Two-cycle pulse is rejected
        sticky_rise = 8'h00;
        sticky_fall = 8'h00;
        set_d(8'h01);
        run(2);
        set_d(8'h00);
        for (int k = 0; k < 8; k++) begin
            step();
            sticky_rise |= b0.RISE;
            sticky_fall |= b0.FALL;
        end
        check("glitch2_q",    b0.Q, 8'h00);
        check("glitch2_rise", sticky_rise, 8'h00);
        check("glitch2_fall", sticky_fall, 8'h00);

        // Bounce 1,1,0,1,1,1 restarts the count
        sticky_rise = 8'h00;
        for (int k = 0; k < 7; k++) begin
            set_d(bounce[k]);
            step();
            sticky_rise |= b0.RISE;
        end
        check("bounce_e7_q",    b0.Q, 8'h00);
        check("bounce_e7_rise", sticky_rise, 8'h00);
        set_d(bounce[7]);
        step();
        check("bounce_e8_q",    b0.Q, 8'h01);
        check("bounce_e8_rise", b0.RISE, 8'h01);
        set_d(8'h00);
        run(8);
        check("bounce_settle_q", b0.Q, 8'h00);

        // Simultaneous events on channels 7 and 0
        set_d(8'h81);
        run(2);
        check("sim_fast_q", b1.Q, 8'h81);
        run(2);
        check("sim_e4_changed", b0.CHANGED, 1'b0);
        step();
        check("sim_e5_rise",    b0.RISE, 8'h81);
        check("sim_e5_changed", b0.CHANGED, 1'b1);
        check("sim_e5_q",       b0.Q, 8'h81);
        step();
        check("sim_e6_changed", b0.CHANGED, 1'b0);
        check("sim_e6_rise",    b0.RISE, 8'h00);
        set_d(8'h00);
        run(6);
        check("sim_settle_q", b0.Q, 8'h00);

        // EN low for three edges mid-count
        sticky_rise = 8'h00;
        set_d(8'h08);
        run(4);
        set_en(1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            sticky_rise |= b0.RISE;
        end
        check("en_frozen_q",    b0.Q, 8'h00);
        check("en_frozen_rise", sticky_rise, 8'h00);
        check("en_frozen_chg",  b0.CHANGED, 1'b0);
        set_en(1'b1);
        step();
        check("en_e8_q",    b0.Q, 8'h08);
        check("en_e8_rise", b0.RISE, 8'h08);
        step();
        check("en_e9_rise", b0.RISE, 8'h00);

        // Reset with a partial count pending
        set_d(8'h00);
        run(4);
        check("rstmid_e4_q", b0.Q, 8'h08);
        nCLR = 1'b0;
        step();
        check("rstmid_q",       b0.Q, 8'h00);
        check("rstmid_fall",    b0.FALL, 8'h00);
        check("rstmid_changed", b0.CHANGED, 1'b0);
        nCLR = 1'b1;
        sticky_rise = 8'h00;
        sticky_fall = 8'h00;
        for (int k = 0; k < 6; k++) begin
            step();
            sticky_rise |= b0.RISE;
            sticky_fall |= b0.FALL;
        end
        check("rstmid_after_rise", sticky_rise, 8'h00);
        check("rstmid_after_fall", sticky_fall, 8'h00);
        check("rstmid_after_q",    b0.Q, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
